// File: rtl/hazard_control_unit.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use and branch-in-ID
// interlocks, a multi-cycle MDU busy tracker, and saturating stall/flush counters.
module hazard_control_unit #(
    parameter int REG_AW      = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic              id_branch_taken,
    input  logic              id_mdu_start,
    input  logic              id_mdu_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_mem_read,
    input  logic              cnt_clear,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              control_mux,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic {
        IDLE,
        BUSY
    } mdu_state_t;

    localparam logic [7:0] MDU_LOAD = 8'(MDU_LATENCY);

    mdu_state_t       state_q, state_d;
    logic [7:0]       mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic match_ex, match_mem;
    logic stall, mdu_accept;

    // Register 0 is hard-wired to zero, so a write to it can never be a true dependency.
    assign match_ex  = (ex_rd != '0) &&
                       ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    assign match_mem = (mem_rd != '0) &&
                       ((id_uses_rs && mem_rd == id_rs) || (id_uses_rt && mem_rd == id_rt));

    assign mdu_busy   = (mdu_cnt_q != '0);
    assign stall      = (ex_mem_read && match_ex) ||
                        (id_branch && ex_reg_write && match_ex) ||
                        (id_branch && mem_mem_read && match_mem) ||
                        (mdu_busy && (id_mdu_start || id_mdu_read));
    assign mdu_accept = id_mdu_start && !stall;

    always_comb begin
        // NOTE: every output gets a default first so no path through the ifs infers a latch.
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        control_mux = 1'b1;
        if (!reset) begin
            if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                control_mux = 1'b0;
            end else if (id_branch && id_branch_taken) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        case (state_q)
            IDLE: begin
                if (mdu_accept) begin
                    mdu_cnt_d = MDU_LOAD;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                mdu_cnt_d = mdu_cnt_q - 8'd1;
                if (mdu_cnt_q == 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (cnt_clear) begin
            stall_count_d = '0;
            flush_count_d = '0;
        end else begin
            if (stall && stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
            if (ifid_flush && flush_count_q != '1) flush_count_d = flush_count_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments and an async reset, so reset aborts the MDU at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mdu_cnt_q     <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mdu_cnt_q     <= mdu_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios followed by random traffic,
// all compared each cycle against a cycle-numbered behavioural model.
module tb_hazard_control_unit;

    localparam int AW   = 5;
    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
    logic          id_uses_rs, id_uses_rt, id_branch, id_branch_taken;
    logic          id_mdu_start, id_mdu_read, ex_reg_write, ex_mem_read, mem_mem_read;
    logic          cnt_clear;
    logic          pc_write, ifid_write, ifid_flush, control_mux, mdu_busy;
    logic [CW-1:0] stall_count, flush_count;

    hazard_control_unit #(.REG_AW(AW), .MDU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_branch_taken(id_branch_taken),
        .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .cnt_clear(cnt_clear),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .control_mux(control_mux), .mdu_busy(mdu_busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_until = -1;     // last cycle number in which the MDU is occupied
    int m_stalls = 0;
    int m_flushes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit reads(input logic [AW-1:0] r);
        return (r != 0) && ((id_uses_rs && r == id_rs) || (id_uses_rt && r == id_rt));
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; cnt_clear = 1'b0;
        id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_branch = 1'b0; id_branch_taken = 1'b0;
        id_mdu_start = 1'b0; id_mdu_read = 1'b0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_mem_read = 1'b0;
    endtask

    // Inputs are applied just after a rising edge; outputs are sampled mid-cycle, then the
    // model advances across the next edge.
    task automatic run_cycle();
        bit busy, stall, flush;
        #3;
        if (reset) begin
            busy_until = -1;
            m_stalls   = 0;
            m_flushes  = 0;
        end
        busy  = (cyc <= busy_until);
        stall = (ex_mem_read && reads(ex_rd)) ||
                (id_branch && ex_reg_write && reads(ex_rd)) ||
                (id_branch && mem_mem_read && reads(mem_rd)) ||
                (busy && (id_mdu_start || id_mdu_read));
        if (reset) stall = 0;
        flush = !stall && !reset && id_branch && id_branch_taken;

        check("pc_write",    32'(pc_write),    32'(!stall));
        check("ifid_write",  32'(ifid_write),  32'(!stall));
        check("control_mux", 32'(control_mux), 32'(!stall));
        check("ifid_flush",  32'(ifid_flush),  32'(flush));
        check("mdu_busy",    32'(mdu_busy),    32'(busy));
        check("stall_count", 32'(stall_count), 32'(m_stalls));
        check("flush_count", 32'(flush_count), 32'(m_flushes));

        if (!reset) begin
            if (id_mdu_start && !stall) busy_until = cyc + LAT;
            if (cnt_clear) begin
                m_stalls  = 0;
                m_flushes = 0;
            end else begin
                if (stall && m_stalls < CMAX)  m_stalls++;
                if (flush && m_flushes < CMAX) m_flushes++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        run_cycle();

        // Load-use: one stall, then the load sits in MEM and a plain consumer proceeds.
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
        run_cycle();
        ex_mem_read = 0; mem_mem_read = 1; mem_rd = 8;
        run_cycle();
        idle_inputs();
        ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        run_cycle();

        // Taken branch on a load: two stall cycles, then a single flush.
        idle_inputs(); cnt_clear = 1; run_cycle(); cnt_clear = 0;
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9;
        id_branch = 1; id_branch_taken = 1; id_rs = 9; id_uses_rs = 1;
        run_cycle();
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; mem_mem_read = 1; mem_rd = 9;
        run_cycle();
        mem_mem_read = 0; mem_rd = 0;
        run_cycle();
        idle_inputs();
        run_cycle();

        // Branch on an ALU result, then the same operand marked unused.
        ex_reg_write = 1; ex_rd = 5; id_branch = 1; id_rt = 5; id_uses_rt = 1;
        run_cycle();
        id_uses_rt = 0;
        run_cycle();

        // MDU: mult accepted, then mflo waits out the latency.
        idle_inputs(); id_mdu_start = 1; run_cycle();
        id_mdu_start = 0; id_mdu_read = 1;
        repeat (LAT + 2) run_cycle();

        // Reset asserted mid-BUSY, then mflo proceeds.
        idle_inputs(); id_mdu_start = 1; run_cycle();
        id_mdu_start = 0; run_cycle();
        reset = 1; run_cycle();
        reset = 0; id_mdu_read = 1; run_cycle();

        // Saturation, then clear while the stall persists.
        idle_inputs(); ex_mem_read = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1;
        repeat (20) run_cycle();
        cnt_clear = 1; run_cycle();
        cnt_clear = 0; run_cycle();

        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            cnt_clear       = ($urandom_range(0, 19) == 0);
            id_rs           = AW'($urandom_range(0, 3));
            id_rt           = AW'($urandom_range(0, 3));
            ex_rd           = AW'($urandom_range(0, 3));
            mem_rd          = AW'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_branch       = ($urandom_range(0, 3) == 0);
            id_branch_taken = 1'($urandom_range(0, 1));
            id_mdu_start    = ($urandom_range(0, 5) == 0);
            id_mdu_read     = ($urandom_range(0, 3) == 0);
            ex_reg_write    = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 3) == 0);
            mem_mem_read    = ($urandom_range(0, 3) == 0);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised hazard and stall controller for the 5-stage MIPS pipeline, sitting beside the ID stage and driving PC, IF/ID and ID/EX control. It generalises the load-use and branch-in-ID hazard logic to a configurable register-address width with register-0 exclusion and per-operand use qualifiers. It adds a multi-cycle MDU (mult/div) busy tracker with a counter-based state machine and saturating stall and flush performance counters.

## Interface
- REG_AW, 5, register-address width
- MDU_LATENCY, 4, MDU busy cycles after a mult/div is accepted; legal range 1..255
- CNT_W, 16, performance counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  operand actually read by the ID instruction
- id_branch  in  1  ID instruction is a branch, resolved in ID
- id_branch_taken  in  1  branch comparator result
- id_mdu_start  in  1  ID instruction is mult/div
- id_mdu_read  in  1  ID instruction is mfhi/mflo
- ex_rd  in  REG_AW  destination of the ID/EX instruction, already muxed
- ex_reg_write, ex_mem_read  in  1  ID/EX control bits
- mem_rd  in  REG_AW  destination of the EX/MEM instruction
- mem_mem_read  in  1  EX/MEM instruction is a load
- cnt_clear  in  1  synchronous clear of both counters
- pc_write  out  1  1 = PC updates
- ifid_write  out  1  1 = IF/ID loads
- ifid_flush  out  1  1 = IF/ID loads a NOP
- control_mux  out  1  1 = pass ID control into ID/EX, 0 = bubble
- mdu_busy  out  1  MDU occupied
- stall_count  out  CNT_W  cycles with stall asserted
- flush_count  out  CNT_W  cycles with ifid_flush asserted

## Operation
- match_X(r) = (r != 0) && ((id_uses_rs && r == id_rs) || (id_uses_rt && r == id_rt)). Register 0 never causes a hazard.
- Stall terms, ORed into stall:
  - load-use: ex_mem_read && match(ex_rd)
  - branch on EX ALU result: id_branch && ex_reg_write && match(ex_rd)
  - branch on load in MEM: id_branch && mem_mem_read && match(mem_rd)
  - MDU: mdu_busy && (id_mdu_start || id_mdu_read)
- Output priority:
  - stall: pc_write=0, ifid_write=0, control_mux=0, ifid_flush=0. A pending taken branch is not flushed until its operands are safe.
  - else id_branch && id_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, control_mux=1.
  - else: 1,1,0,1.
- MDU state machine with states IDLE and BUSY, and an 8-bit down-counter mdu_cnt.
  - mdu_busy = (mdu_cnt != 0), which means BUSY.
  - Accept condition: id_mdu_start && !stall. On accept, mdu_cnt is loaded with MDU_LATENCY at the clock edge.
  - In BUSY, mdu_cnt decrements by 1 per cycle. It returns to IDLE on reaching 0.
  - Accept is impossible while BUSY, because an MDU start during BUSY is itself a stall term.
- Counters:
  - stall_count increments in every cycle stall=1.
  - flush_count increments in every cycle ifid_flush=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clear forces both to 0, taking priority over increment.
  - The MDU counter is not affected by cnt_clear.

## Timing
- All hazard outputs are combinational from inputs plus mdu_cnt, with zero-cycle latency. Only mdu_cnt and the counters are registered.
- Reset values: pc_write=1, ifid_write=1, ifid_flush=0, control_mux=1, mdu_busy=0, stall_count=0, flush_count=0, mdu_cnt=0.
  - While reset is high, the hazard outputs are forced to these values regardless of inputs.
  - Reset mid-BUSY aborts the MDU immediately, asynchronously.
- MDU timing: for a start accepted in cycle T, mdu_busy is high in cycles T+1 .. T+MDU_LATENCY. An mfhi/mflo presented in any of those cycles stalls until cycle T+MDU_LATENCY+1.
- Load-use stalls for exactly 1 cycle. On the next cycle the load is in MEM, so a non-branch consumer proceeds.
- A branch depending on a load stalls for 2 cycles: first on the load-use term, then on the MEM-load term.
- Simultaneous events:
  - Stall and taken branch together: the stall wins and the flush is deferred.
  - A counter at max with a new event holds at max.
  - cnt_clear together with an event gives 0.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> pc_write=0, ifid_write=0, control_mux=0 for 1 cycle, stall_count=1. Repeat with ex_rd=0 -> no stall.
- Branch after load: lw $9, then beq $9 (taken) -> 2 stall cycles, then ifid_flush=1 for 1 cycle. Expect stall_count=2, flush_count=1.
- Branch after ALU op: ex_reg_write=1, ex_rd=5, id_branch=1, id_rt=5, id_uses_rt=1 -> 1 stall cycle. With id_uses_rt=0 -> no stall.
- MDU with MDU_LATENCY=4: mult accepted at T, mflo presented at T+1 -> stall for T+1..T+4, proceeds at T+5. mdu_busy is high for exactly 4 cycles.
- Reset mid-operation: assert reset at T+2 during BUSY -> mdu_busy=0 and counters 0 asynchronously, and outputs take their default values. After release, mflo proceeds without stall.
- Saturation with CNT_W=4: hold a stall for 20 cycles -> stall_count=15. Then cnt_clear while stalling -> 0.
